// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the binary-to-BCD controller.
//   state_t   : controller states (IDLE/CONV/DONE)
//   SEG_*     : active-low 7-segment patterns, bit order g..a
//   SEG_TABLE : digit 0-9 to segment pattern
//   BCD_MAX   : largest value that converts without error
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  localparam logic [6:0] BCD_MAX = 7'd99;

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: combinational BCD digit to active-low 7-segment decoder.
//   digit : 4-bit BCD digit (codes above 9 decode to blank)
//   seg   : segments g..a, active-low
module seg7_dec
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/bcd_conv_ctrl.sv
// bcd_conv_ctrl: converts a 7-bit binary value to two BCD digits by repeated
// subtraction of ten, and drives registered 7-segment patterns for both digits.
// Values above 99 produce err=1 and a dash on both displays.
//   Clock, Resetn       : clock, synchronous active-low reset
//   in_valid, in_data   : value to convert (accepted when in_ready=1)
//   in_ready            : high in IDLE and DONE
//   out_valid           : tens/ones/err/HEX hold a completed result
//   tens, ones, err     : last result
//   HEX1, HEX0          : registered active-low segments for tens/ones
// Optional build macro BCD_BLANK_LEADING_ZERO_EN: blank HEX1 when tens=0 and
// err=0 (reset value included).
//
// state | meaning
// IDLE  | waiting for first value, in_ready=1
// CONV  | subtracting ten per edge, inputs ignored
// DONE  | result held, in_ready=1, a new accept restarts
module bcd_conv_ctrl
  import bcd_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       in_valid,
  input  logic [6:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       err,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

`ifdef BCD_BLANK_LEADING_ZERO_EN
  localparam logic BLANK_LZ = 1'b1;
`else
  localparam logic BLANK_LZ = 1'b0;
`endif

  localparam logic [6:0] HEX1_ZERO = BLANK_LZ ? SEG_BLANK : SEG_TABLE[0];

  state_t     state;
  logic [6:0] rem;
  logic [3:0] tens_acc;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
  logic [6:0] hex1_next;

  // Decoders look at the working registers so the patterns are ready on the
  // very edge that publishes the digits.
  seg7_dec u_dec_tens (.digit(tens_acc),  .seg(seg_tens));
  seg7_dec u_dec_ones (.digit(rem[3:0]), .seg(seg_ones));

  assign hex1_next = (BLANK_LZ && (tens_acc == 4'd0)) ? SEG_BLANK : seg_tens;
  assign in_ready  = (state != CONV);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= IDLE;
      rem       <= 7'd0;
      tens_acc  <= 4'd0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      tens      <= 4'd0;
      ones      <= 4'd0;
      HEX0      <= SEG_TABLE[0];
      HEX1      <= HEX1_ZERO;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (in_valid) begin
            rem       <= in_data;
            tens_acc  <= 4'd0;
            out_valid <= 1'b0;
            state     <= CONV;
          end
        end
        CONV: begin
          // Out-of-range check must win over the subtract step, otherwise
          // tens_acc would run past 9.
          if (rem > BCD_MAX) begin
            tens      <= 4'd0;
            ones      <= 4'd0;
            err       <= 1'b1;
            out_valid <= 1'b1;
            HEX0      <= SEG_DASH;
            HEX1      <= SEG_DASH;
            state     <= DONE;
          end else if (rem >= 7'd10) begin
            rem      <= rem - 7'd10;
            tens_acc <= tens_acc + 4'd1;
          end else begin
            ones      <= rem[3:0];
            tens      <= tens_acc;
            err       <= 1'b0;
            out_valid <= 1'b1;
            HEX0      <= seg_ones;
            HEX1      <= hex1_next;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// tb_bcd_conv_ctrl: directed bench for bcd_conv_ctrl with an arithmetic
// reference model compared on every falling edge, plus literal checks.
module tb_bcd_conv_ctrl;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       in_valid;
  logic [6:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] tens, ones;
  logic       err;
  logic [6:0] HEX1, HEX0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  bcd_conv_ctrl dut (
    .Clock(Clock), .Resetn(Resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .tens(tens), .ones(ones),
    .err(err), .HEX1(HEX1), .HEX0(HEX0)
  );

  always #5 Clock = ~Clock;

`ifdef BCD_BLANK_LEADING_ZERO_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a value is a job that takes (value/10)+1 edges, or one
  // edge when out of range; the result is plain division/modulo.
  int m_busy = 0;
  int m_val = 0;
  bit m_ov = 0, m_err = 0;
  int m_tens = 0, m_ones = 0;

  always @(posedge Clock) begin
    if (!Resetn) begin
      m_busy = 0; m_ov = 0; m_err = 0; m_tens = 0; m_ones = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_ov = 1;
        if (m_val > 99) begin
          m_err = 1; m_tens = 0; m_ones = 0;
        end else begin
          m_err = 0; m_tens = m_val / 10; m_ones = m_val % 10;
        end
      end
    end else if (in_valid) begin
      m_val  = int'(in_data);
      m_busy = (m_val > 99) ? 1 : m_val / 10 + 1;
      m_ov   = 0;
    end
  end

  function automatic logic [6:0] exp_hex1();
    if (m_err) return 7'b0111111;
    if (BLANK && m_tens == 0) return 7'b1111111;
    return seg_of(m_tens);
  endfunction

  function automatic logic [6:0] exp_hex0();
    if (m_err) return 7'b0111111;
    return seg_of(m_ones);
  endfunction

  always @(negedge Clock) begin
    if (chk_en) begin
      check("in_ready",  int'(in_ready),  int'(m_busy == 0));
      check("out_valid", int'(out_valid), int'(m_ov));
      check("tens",      int'(tens),      m_tens);
      check("ones",      int'(ones),      m_ones);
      check("err",       int'(err),       int'(m_err));
      check("HEX1",      int'(HEX1),      int'(exp_hex1()));
      check("HEX0",      int'(HEX0),      int'(exp_hex0()));
    end
  end

  // Accept one value, release in_valid, return edges until out_valid.
  task automatic convert(input int v, output int lat);
    @(negedge Clock);
    in_valid = 1'b1;
    in_data  = 7'(v);
    @(negedge Clock);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge Clock);
      lat++;
    end
  endtask

  int lat;

  initial begin
    Resetn = 1'b0; in_valid = 1'b0; in_data = 7'd0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    chk_en = 1'b1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_HEX0", int'(HEX0), int'(7'b1000000));
    check("rst_HEX1", int'(HEX1), BLANK ? int'(7'b1111111) : int'(7'b1000000));

    convert(57, lat);
    check("lat57", lat, 6);
    check("tens57", int'(tens), 5);
    check("ones57", int'(ones), 7);
    check("HEX1_57", int'(HEX1), int'(7'b0010010));
    check("HEX0_57", int'(HEX0), int'(7'b1111000));

    convert(0, lat);
    check("lat0", lat, 1);
    check("HEX1_0", int'(HEX1), BLANK ? int'(7'b1111111) : int'(7'b1000000));

    convert(99, lat);
    check("lat99", lat, 10);
    check("tens99", int'(tens), 9);
    check("ones99", int'(ones), 9);

    convert(100, lat);
    check("lat100", lat, 1);
    check("err100", int'(err), 1);
    check("HEX1_100", int'(HEX1), int'(7'b0111111));

    convert(127, lat);
    check("lat127", lat, 1);
    check("HEX0_127", int'(HEX0), int'(7'b0111111));

    convert(10, lat);
    check("lat10", lat, 2);
    check("ones10", int'(ones), 0);

    // in_valid held high with changing data during CONV, then back-to-back.
    @(negedge Clock);
    in_valid = 1'b1;
    in_data  = 7'd35;
    @(negedge Clock);
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_data = 7'($urandom_range(0, 127));
      @(negedge Clock);
      lat++;
    end
    check("lat35", lat, 4);
    check("tens35", int'(tens), 3);
    check("ones35", int'(ones), 5);
    in_data = 7'd12;
    @(negedge Clock);
    in_valid = 1'b0;
    check("b2b_drop", int'(out_valid), 0);
    check("b2b_hold_tens", int'(tens), 3);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge Clock);
      lat++;
    end
    check("tens12", int'(tens), 1);
    check("ones12", int'(ones), 2);

    // Reset on the 3rd CONV edge of 80 aborts the conversion.
    @(negedge Clock);
    in_valid = 1'b1;
    in_data  = 7'd80;
    @(negedge Clock);
    in_valid = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    check("abort_ov", int'(out_valid), 0);
    check("abort_ready", int'(in_ready), 1);
    check("abort_HEX0", int'(HEX0), int'(7'b1000000));
    convert(42, lat);
    check("lat42", lat, 5);
    check("tens42", int'(tens), 4);
    check("ones42", int'(ones), 2);

    // Reset wins over an accept on the same edge.
    @(negedge Clock);
    Resetn = 1'b0; in_valid = 1'b1; in_data = 7'd50;
    @(negedge Clock);
    Resetn = 1'b1; in_valid = 1'b0;
    check("rst_prio_ready", int'(in_ready), 1);
    check("rst_prio_ov", int'(out_valid), 0);

    repeat (3) @(negedge Clock);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_conv_ctrl.md
BCD_CONV_CTRL -- requirements
Module: bcd_conv_ctrl

Interface
REQ-001 SHALL have port Clock  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port Resetn  in  1  reset, synchronous and active-low.
REQ-003 SHALL have port in_valid  in  1  producer has a value on in_data.
REQ-004 SHALL have port in_data  in  7  unsigned binary value to convert.
REQ-005 SHALL have port in_ready  out  1  controller can accept a value.
REQ-006 SHALL have port out_valid  out  1  tens/ones/err/HEX hold a completed result.
REQ-007 SHALL have port tens  out  4  BCD tens digit of the last result.
REQ-008 SHALL have port ones  out  4  BCD ones digit of the last result.
REQ-009 SHALL have port err  out  1  last accepted value was above 99.
REQ-010 SHALL have port HEX1  out  7  active-low segments (g..a) for tens.
REQ-011 SHALL have port HEX0  out  7  active-low segments (g..a) for ones.

Function
REQ-012 SHALL use three states: IDLE, CONV, DONE.
REQ-013 SHALL drive in_ready=1 in IDLE and DONE, and 0 in CONV.
REQ-014 SHALL accept on an edge with in_valid=1 and in_ready=1: rem<=in_data, tens_acc<=0, out_valid<=0, state<=CONV.
REQ-015 SHALL ignore in_valid while in CONV; in_data is not sampled.
REQ-016 SHALL, per CONV edge: rem>=10 -> rem<=rem-10 and tens_acc<=tens_acc+1; else ones<=rem[3:0], tens<=tens_acc, err<=0, out_valid<=1, state<=DONE.
REQ-017 SHALL, on the first CONV edge with rem>99: tens<=0, ones<=0, err<=1, out_valid<=1, state<=DONE.
REQ-018 SHALL raise out_valid exactly tens+1 edges after the accept edge (value 0: 1 edge; value 99: 10 edges; err: 1 edge).
REQ-019 SHALL hold out_valid, tens, ones, err, HEX0 and HEX1 stable in DONE until the next accept.
REQ-020 SHALL clear out_valid on the accept edge taken in DONE; tens/ones/HEX keep the old result until the new one completes.
REQ-021 SHALL register HEX0/HEX1, updating them on the same edge as tens/ones.
REQ-022 SHALL use standard 7-seg encoding for 0-9 (0=1000000, 1=1111001); when err=1, HEX1=HEX0=0111111 (dash).
REQ-023 SHALL keep rem 7 bits and tens_acc 4 bits; tens_acc never exceeds 9.

Reset
REQ-024 SHALL, on an edge with Resetn=0: state<=IDLE, out_valid=0, err=0, tens=0, ones=0, HEX0=HEX1=1000000, in_ready=1 next cycle.
REQ-025 SHALL abort a conversion in progress when Resetn=0; no result is produced.
REQ-026 SHALL give Resetn priority over an accept on the same edge.

Configuration
REQ-027 SHALL support macro BCD_BLANK_LEADING_ZERO_EN.
REQ-028 SHALL, when BCD_BLANK_LEADING_ZERO_EN is defined, drive HEX1=1111111 (blank) whenever tens=0 and err=0, including the reset value.
REQ-029 SHALL, when BCD_BLANK_LEADING_ZERO_EN is undefined, display tens=0 as 1000000.
REQ-030 SHALL leave tens and ones port values unchanged by the macro.

Structure
REQ-031 SHALL take from shared package bcd_pkg: the state enum (IDLE/CONV/DONE), SEG_BLANK, SEG_DASH, the 10-entry digit-to-segment table, and constant BCD_MAX=99.
REQ-032 SHALL instantiate sub-module seg7_dec (4-bit BCD in, 7-bit active-low segments out) twice, once per digit.

Verification
REQ-033 SHALL cover: reset, then in_data=57 with in_valid pulse -> out_valid rises 6 edges after accept; tens=5, ones=7, HEX1=0010010, HEX0=1111000.
REQ-034 SHALL cover: in_data=0 -> out_valid after 1 edge; tens=0, ones=0; HEX1=1000000 (macro off) / 1111111 (macro on).
REQ-035 SHALL cover: in_data=99 -> 10-edge latency, tens=9, ones=9; in_data=100 and 127 -> err=1, both HEX=0111111, latency 1.
REQ-036 SHALL cover: in_valid held high with in_data changing during CONV -> in_ready=0 and the result reflects only the accepted value; a back-to-back accept in DONE drops out_valid on the next edge.
REQ-037 SHALL cover: Resetn=0 at the 3rd CONV edge of in_data=80 -> IDLE, out_valid=0, HEX reset pattern; a following in_data=42 converts to 4/2.
